// File: rtl/dmem_dump_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_dump_tx_pkg
// Description : Shared widths, FSM encodings, UART frame constants and a
//               byte-select helper for the data-memory dump transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_dump_tx_pkg;

    localparam int DMEM_ADDR_LEN   = 32;
    localparam int DMEM_DATA_LEN   = 32;

    localparam int UART_FRAME_BITS = 10;
    localparam int UART_DATA_BITS  = 8;

    typedef enum logic [2:0] {
        DUMP_IDLE  = 3'd0,
        DUMP_FETCH = 3'd1,
        DUMP_LOAD  = 3'd2,
        DUMP_SEND  = 3'd3,
        DUMP_FIN   = 3'd4
    } dump_state_t;

    // Little-endian byte lane select of a memory word.
    function automatic logic [7:0] word_byte(input logic [DMEM_DATA_LEN-1:0] w,
                                             input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        return b;
    endfunction

endpackage : dmem_dump_tx_pkg
`default_nettype wire

// File: rtl/dmem_dump_tx_uart_byte_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_byte_tx
// Description : 8N1 byte serialiser with valid/ready input. A new byte can be
//               taken on the last cycle of the current stop bit, so frames
//               can be sent back to back with no idle bits between them.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_byte_tx
    import dmem_dump_tx_pkg::*;
#(
    parameter int BAUD_DIV = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       ready,
    output logic       frame_end,
    output logic       txd
);

    localparam int              c_bw        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [c_bw-1:0] c_baud_last = c_bw'(BAUD_DIV - 1);
    localparam logic [3:0]      c_bit_last  = 4'(UART_FRAME_BITS - 1);

    logic            r_active;
    logic [c_bw-1:0] r_baud;
    logic [3:0]      r_bit;
    logic [9:0]      r_shift;
    logic            r_txd;

    logic            w_bit_end;
    logic            w_accept;
    logic [9:0]      w_frame;

    assign w_bit_end = r_active && (r_baud == c_baud_last);
    assign frame_end = w_bit_end && (r_bit == c_bit_last);
    // The final cycle of a stop bit counts as idle for handshake purposes.
    assign ready     = !r_active || frame_end;
    assign w_accept  = valid && ready;
    assign w_frame   = {1'b1, data, 1'b0};
    assign txd       = r_txd;

    // Baud counter, bit counter and frame shifter; txd is driven from a flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_active <= 1'b0;
            r_baud   <= '0;
            r_bit    <= 4'd0;
            r_shift  <= '1;
            r_txd    <= 1'b1;
        end else if (w_accept) begin
            r_active <= 1'b1;
            r_baud   <= '0;
            r_bit    <= 4'd0;
            r_txd    <= w_frame[0];
            r_shift  <= {1'b1, w_frame[9:1]};
        end else if (frame_end) begin
            r_active <= 1'b0;
            r_baud   <= '0;
            r_bit    <= 4'd0;
            r_txd    <= 1'b1;
        end else if (w_bit_end) begin
            r_baud   <= '0;
            r_bit    <= r_bit + 4'd1;
            r_txd    <= r_shift[0];
            r_shift  <= {1'b1, r_shift[9:1]};
        end else if (r_active) begin
            r_baud   <= r_baud + c_bw'(1);
        end
    end

endmodule : uart_byte_tx
`default_nettype wire

// File: rtl/dmem_dump_tx.sv
`default_nettype none
// ============================================================================
// Module      : dmem_dump_tx
// Description : Reads DUMP_WORDS words of data memory from a latched base
//               address and transmits every byte, little-endian, as 8N1 UART
//               frames. Optional macro DMEM_DUMP_CHECKSUM_EN appends the
//               32-bit running sum of all words as four extra bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_dump_tx
    import dmem_dump_tx_pkg::*;
#(
    parameter int ADDR_LEN   = DMEM_ADDR_LEN,
    parameter int DATA_LEN   = DMEM_DATA_LEN,
    parameter int BAUD_DIV   = 868,
    parameter int DUMP_WORDS = 512
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_LEN-1:0] base_addr,
    output logic [ADDR_LEN-1:0] mem_addr,
    output logic                mem_re,
    input  logic [DATA_LEN-1:0] mem_rdata,
    output logic                txd,
    output logic                busy,
    output logic                done
);

    localparam int              c_cw       = $clog2(DUMP_WORDS + 1);
    localparam logic [c_cw-1:0] c_cnt_last = c_cw'(DUMP_WORDS);

    dump_state_t         r_state;
    dump_state_t         w_state_next;
    logic [ADDR_LEN-1:0] r_addr;
    logic [c_cw-1:0]     r_cnt;
    logic [DATA_LEN-1:0] r_word;
    logic [1:0]          r_idx;

    logic [c_cw-1:0]     w_cnt_inc;
    logic                w_last_word;
    logic                w_word_done;
    logic                w_tx_valid;
    logic [7:0]          w_tx_data;
    logic                w_tx_ready;
    logic                w_frame_end;
    logic [ADDR_LEN-1:0] w_base_aligned;

`ifdef DMEM_DUMP_CHECKSUM_EN
    logic [DATA_LEN-1:0] r_sum;
    logic                r_csum_phase;
    logic                w_csum_load;
`endif

    assign w_base_aligned = base_addr & {{(ADDR_LEN-2){1'b1}}, 2'b00};
    assign w_cnt_inc      = r_cnt + c_cw'(1);
    assign w_last_word    = (w_cnt_inc == c_cnt_last);

    assign mem_re   = (r_state == DUMP_FETCH);
    assign mem_addr = (r_state == DUMP_FETCH) ? r_addr : '0;
    assign busy     = (r_state != DUMP_IDLE);
    assign done     = (r_state == DUMP_FIN);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= DUMP_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and transmitter handshake. Byte 0 goes straight from
    // mem_rdata during LOAD so its start bit appears on the first SEND cycle.
    always_comb begin
        w_state_next = r_state;
        w_tx_valid   = 1'b0;
        w_tx_data    = 8'h00;
        w_word_done  = 1'b0;
`ifdef DMEM_DUMP_CHECKSUM_EN
        w_csum_load  = 1'b0;
`endif
        case (r_state)
            DUMP_IDLE: begin
                if (start) begin
                    w_state_next = DUMP_FETCH;
                end
            end
            DUMP_FETCH: begin
                w_state_next = DUMP_LOAD;
            end
            DUMP_LOAD: begin
                w_tx_valid   = 1'b1;
                w_tx_data    = mem_rdata[7:0];
                w_state_next = DUMP_SEND;
            end
            DUMP_SEND: begin
                if (w_frame_end) begin
                    if (r_idx != 2'd3) begin
                        w_tx_valid = 1'b1;
                        w_tx_data  = word_byte(r_word, r_idx + 2'd1);
                    end else begin
`ifdef DMEM_DUMP_CHECKSUM_EN
                        if (r_csum_phase) begin
                            w_state_next = DUMP_FIN;
                        end else begin
                            w_word_done = 1'b1;
                            if (w_last_word) begin
                                // Sum already includes the last word.
                                w_csum_load = 1'b1;
                                w_tx_valid  = 1'b1;
                                w_tx_data   = r_sum[7:0];
                            end else begin
                                w_state_next = DUMP_FETCH;
                            end
                        end
`else
                        w_word_done  = 1'b1;
                        w_state_next = w_last_word ? DUMP_FIN : DUMP_FETCH;
`endif
                    end
                end
            end
            DUMP_FIN: begin
                w_state_next = DUMP_IDLE;
            end
            default: begin
                w_state_next = DUMP_IDLE;
            end
        endcase
    end

    // Address, word counter, captured word and byte index datapath.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr       <= '0;
            r_cnt        <= '0;
            r_word       <= '0;
            r_idx        <= 2'd0;
`ifdef DMEM_DUMP_CHECKSUM_EN
            r_sum        <= '0;
            r_csum_phase <= 1'b0;
`endif
        end else begin
            case (r_state)
                DUMP_IDLE: begin
                    if (start) begin
                        r_addr       <= w_base_aligned;
                        r_cnt        <= '0;
`ifdef DMEM_DUMP_CHECKSUM_EN
                        r_sum        <= '0;
                        r_csum_phase <= 1'b0;
`endif
                    end
                end
                DUMP_LOAD: begin
                    r_word <= mem_rdata;
                    r_idx  <= 2'd0;
`ifdef DMEM_DUMP_CHECKSUM_EN
                    r_sum  <= r_sum + mem_rdata;
`endif
                end
                DUMP_SEND: begin
                    if (w_tx_valid) begin
                        r_idx <= r_idx + 2'd1;
                    end
                    if (w_word_done) begin
                        r_cnt  <= w_cnt_inc;
                        r_addr <= r_addr + ADDR_LEN'(4);
                    end
`ifdef DMEM_DUMP_CHECKSUM_EN
                    if (w_csum_load) begin
                        r_word       <= r_sum;
                        r_csum_phase <= 1'b1;
                    end
`endif
                end
                default: begin
                end
            endcase
        end
    end

    uart_byte_tx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_uart_byte_tx (
        .clk       (clk),
        .reset     (reset),
        .valid     (w_tx_valid),
        .data      (w_tx_data),
        .ready     (w_tx_ready),
        .frame_end (w_frame_end),
        .txd       (txd)
    );

endmodule : dmem_dump_tx
`default_nettype wire
